// File: rtl/instr_mem_seq_if.sv
// instr_mem_seq_if: fetch/load bus between the core and the instruction memory.
// ld_par_inv exists only when INSTR_MEM_PARITY_EN is defined.
interface instr_mem_seq_if #(
  parameter int INSTR_W = 9,
  parameter int PC_W = 16
);
  logic ready;
  logic fetch_req;
  logic [PC_W-1:0] pc_in;
  logic stall;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0] pc_out;
  logic instr_valid;
  logic addr_fault;
  logic ld_en;
  logic [PC_W-1:0] ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic ld_fault;
  logic parity_err;
`ifdef INSTR_MEM_PARITY_EN
  logic ld_par_inv;
  modport master (
    output fetch_req, pc_in, stall, ld_en, ld_addr, ld_data, ld_par_inv,
    input ready, instr_out, pc_out, instr_valid, addr_fault, ld_fault, parity_err
  );
  modport slave (
    input fetch_req, pc_in, stall, ld_en, ld_addr, ld_data, ld_par_inv,
    output ready, instr_out, pc_out, instr_valid, addr_fault, ld_fault, parity_err
  );
`else
  modport master (
    output fetch_req, pc_in, stall, ld_en, ld_addr, ld_data,
    input ready, instr_out, pc_out, instr_valid, addr_fault, ld_fault, parity_err
  );
  modport slave (
    input fetch_req, pc_in, stall, ld_en, ld_addr, ld_data,
    output ready, instr_out, pc_out, instr_valid, addr_fault, ld_fault, parity_err
  );
`endif
endinterface

// File: rtl/instr_mem_seq.sv
// instr_mem_seq: loadable instruction memory with registered fetch, stall hold and post-reset clear.
// Optional per-word even parity with INSTR_MEM_PARITY_EN.
module instr_mem_seq #(
  parameter int INSTR_W = 9,
  parameter int DEPTH = 64,
  parameter int PC_W = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input logic clk,
  input logic rst_n,
  instr_mem_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PC_W:0] LIMIT = (PC_W+1)'(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = INSTR_W + 1;
`else
  localparam int MW = INSTR_W;
`endif
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word, wr_word;
  logic [AW-1:0] wr_idx;
  logic run, ld_in, fetch_in, fetch_ok, wr_en, rd_err;
  always_comb begin
    run = state == RUN;
    ld_in = {1'b0, bus.ld_addr} < LIMIT;
    fetch_in = {1'b0, bus.pc_in} < LIMIT;
    fetch_ok = run && bus.fetch_req && !bus.stall && !bus.ld_en;
    wr_en = !run || (bus.ld_en && ld_in);
    wr_idx = run ? bus.ld_addr[AW-1:0] : cnt;
    rd_word = mem[bus.pc_in[AW-1:0]];
`ifdef INSTR_MEM_PARITY_EN
    wr_word = run ? {^bus.ld_data ^ bus.ld_par_inv, bus.ld_data} : {^NOP_WORD, NOP_WORD};
    rd_err = ^rd_word;
`else
    wr_word = run ? bus.ld_data : NOP_WORD;
    rd_err = 1'b0;
`endif
  end
  // clear walks the counter through memory; afterwards only in-range loads write
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
      bus.ready <= 1'b0;
      bus.instr_out <= NOP_WORD;
      bus.pc_out <= '0;
      bus.instr_valid <= 1'b0;
      bus.addr_fault <= 1'b0;
      bus.ld_fault <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      if (!run) begin
        cnt <= cnt + 1'b1;
        if (cnt == AW'(DEPTH-1)) begin
          state <= RUN;
          bus.ready <= 1'b1;
        end
      end
      bus.ld_fault <= run && bus.ld_en && !ld_in;
      if (!bus.stall) begin
        bus.instr_valid <= fetch_ok;
        bus.addr_fault <= fetch_ok && !fetch_in;
        bus.parity_err <= fetch_ok && fetch_in && rd_err;
        if (fetch_ok) begin
          bus.pc_out <= bus.pc_in;
          bus.instr_out <= fetch_in ? rd_word[INSTR_W-1:0] : NOP_WORD;
        end
      end
    end
endmodule

// File: doc/instr_mem_seq.md
# instr_mem_seq

Synchronous, parametrised instruction memory that replaces the fixed combinational instruction ROM in the fetch stage. It supports run-time program loading, a registered fetch path with stall hold, out-of-range PC detection and a post-reset clear sequence. It sits between the PC register and the decode stage: the core presents a PC with `fetch_req`, and the block returns the instruction one cycle later with `instr_valid`.

## Interface

Parameters:
- `INSTR_W`, 9: instruction word width.
- `DEPTH`, 64: number of instruction words, at least 2.
- `PC_W`, 16: PC and load-address width.
- `NOP_WORD`, 0 (`INSTR_W` bits): value used for clear and for out-of-range fetch.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ready` out 1: high when in RUN state.
- `fetch_req` in 1: fetch request for `pc_in`.
- `pc_in` in `PC_W`: fetch address.
- `stall` in 1: hold all fetch outputs.
- `instr_out` out `INSTR_W`: fetched instruction.
- `pc_out` out `PC_W`: PC of `instr_out`.
- `instr_valid` out 1: `instr_out` is a fresh fetch result.
- `addr_fault` out 1: fetched PC was at or above `DEPTH`.
- `ld_en` in 1: write `ld_data` to `ld_addr` this cycle.
- `ld_addr` in `PC_W`: load address.
- `ld_data` in `INSTR_W`: load data.
- `ld_fault` out 1: the previous cycle's load was out of range.
- `parity_err` out 1: fetched word failed parity (see Configuration).
- `ld_par_inv` in 1: present only when `INSTR_MEM_PARITY_EN` is defined; inverts the stored parity bit of the current load.

## Operation

- The FSM has two states, CLEAR and RUN. Reset enters CLEAR.
- CLEAR: an internal counter walks addresses 0 to `DEPTH`-1 and writes `NOP_WORD` (with correct parity) at one address per cycle. After the write to `DEPTH`-1 the FSM moves to RUN. While in CLEAR:
  - `ready` is 0.
  - `fetch_req` and `ld_en` are ignored.
- RUN:
  - `ready` is 1.
  - The FSM stays in RUN until reset.
- Load: if in RUN and `ld_en` is high and `ld_addr` < `DEPTH`, `ld_data` is written to `mem[ld_addr]`.
  - If `ld_addr` >= `DEPTH`, nothing is written and `ld_fault` is 1 for the next cycle.
  - Load has priority over fetch. A fetch requested in the same cycle as a load is dropped, and the cycle is treated as a no-fetch cycle (see below).
- Fetch accepted: if in RUN with `fetch_req`=1, `stall`=0 and `ld_en`=0, the next edge registers:
  - `pc_out` = `pc_in`
  - `instr_valid` = 1
  - `instr_out` = `mem[pc_in]`, or `NOP_WORD` with `addr_fault`=1 if `pc_in` >= `DEPTH`
- Stall: if `stall`=1, `instr_out`, `pc_out`, `instr_valid`, `addr_fault` and `parity_err` all hold their values. A load during stall still writes.
- No fetch: if `stall`=0 and no fetch is accepted, `instr_valid`, `addr_fault` and `parity_err` go to 0. `instr_out` and `pc_out` hold.
- Address comparison uses the full `PC_W` width; addresses never wrap modulo `DEPTH`.

## Timing

- Read latency: 1 cycle from the accepting edge. Back-to-back fetches give one instruction per cycle.
- A load at edge N is visible to a fetch accepted at edge N+1 or later.
- CLEAR lasts exactly `DEPTH` cycles after reset deassertion. `ready` rises at the edge that completes the final clear write.
- Reset values (asynchronous):
  - `instr_out` = `NOP_WORD`
  - `pc_out`, `instr_valid`, `addr_fault`, `ld_fault`, `parity_err`, `ready` = 0
  - clear counter = 0
- Reset mid-operation, including during CLEAR or a load burst, aborts the operation immediately and restarts CLEAR. Memory contents are then rewritten to `NOP_WORD`.
- `ld_fault` and `addr_fault` are single-cycle-per-event registered flags. `addr_fault` is exempt from the single-cycle rule while stall holds it.

## Configuration

- `INSTR_MEM_PARITY_EN` defined:
  - Each entry stores an extra even-parity bit computed from the written data, XOR `ld_par_inv` on loads.
  - A fetch result is checked in the same cycle it is registered. `parity_err` = 1 alongside `instr_valid` when stored parity ≠ recomputed parity.
  - Out-of-range fetches report `parity_err` = 0.
- `INSTR_MEM_PARITY_EN` not defined:
  - Memory is `INSTR_W` bits wide.
  - `ld_par_inv` port is absent.
  - `parity_err` is tied to 0.

## Test plan

- Reset release with `DEPTH`=64 -> `ready` is 0 for 64 cycles then 1. A fetch of PC 0..63 returns `NOP_WORD`=0 with `instr_valid`=1 and no faults.
- Load 0x101 at address 5, then fetch PC 5 on the next cycle -> after 1 cycle, `instr_out`=0x101, `pc_out`=5, `instr_valid`=1.
- Fetch PC 3, 4, 5 back-to-back with `stall` high on the second result cycle -> the result for PC 4 holds for 2 cycles and PC 5 follows. Exactly 3 distinct valid results are produced.
- Fetch PC 64 and load at address 70 -> `instr_out`=`NOP_WORD` with `addr_fault`=1; `ld_fault`=1 one cycle after the load; memory is unchanged.
- `ld_en` and `fetch_req` in the same cycle -> no valid output next cycle and the write lands. Asserting `rst_n`=0 at cycle 30 of CLEAR restarts the full 64-cycle clear.
- With `INSTR_MEM_PARITY_EN`: load 0x0AA with `ld_par_inv`=1, then fetch it -> `parity_err`=1, `instr_out`=0x0AA. Without the macro, `parity_err` stays 0.
